// File: rtl/intf_rd_arbiter.sv
// Round-robin read arbiter for the shared intf bus: grants one requester at a
// time, drives the bus master side, waits the read latency and returns the
// captured data with a one-hot response strobe.
module intf_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int RD_LAT  = 2,
    parameter int AW      = 8,
    parameter int DW      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_data,
    output logic                  busy,
    output logic                  bus_read,
    output logic                  bus_enable,
    output logic [AW-1:0]         bus_addr,
    input  logic [DW-1:0]         bus_data
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        win_q, win_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   rspValid_q, rspValid_d;
    logic [DW-1:0]        rspData_q, rspData_d;
    logic                 busRead_q, busRead_d;
    logic                 busEnable_q, busEnable_d;
    logic [AW-1:0]        busAddr_q, busAddr_d;

    logic [IW-1:0]        pick;
    logic                 pickValid;
    logic [IW-1:0]        scanIdx;

    // Round-robin search: first set req bit starting just above the last winner.
    always_comb begin
        pickValid = 1'b0;
        pick      = ptr_q;
        scanIdx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scanIdx = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (!pickValid && req[scanIdx]) begin
                pickValid = 1'b1;
                pick      = scanIdx;
            end
        end
    end

    // Next-state and registered-output logic; strobes default low every cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rspValid_d  = '0;
        rspData_d   = rspData_q;
        busRead_d   = 1'b0;
        busEnable_d = 1'b0;
        busAddr_d   = busAddr_q;
        case (state_q)
            S_IDLE: begin
                if (pickValid) begin
                    gnt_d       = NUM_REQ'(1) << pick;
                    busEnable_d = 1'b1;
                    busRead_d   = 1'b1;
                    busAddr_d   = req_addr[int'(pick)*AW +: AW];
                    ptr_d       = pick;
                    win_d       = pick;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(RD_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rspData_d  = bus_data;
                    rspValid_d = NUM_REQ'(1) << win_q;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight read immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= IW'(NUM_REQ - 1);
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rspValid_q  <= '0;
            rspData_q   <= '0;
            busRead_q   <= 1'b0;
            busEnable_q <= 1'b0;
            busAddr_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rspValid_q  <= rspValid_d;
            rspData_q   <= rspData_d;
            busRead_q   <= busRead_d;
            busEnable_q <= busEnable_d;
            busAddr_q   <= busAddr_d;
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_data   = rspData_q;
    assign busy       = (state_q != S_IDLE);
    assign bus_read   = busRead_q;
    assign bus_enable = busEnable_q;
    assign bus_addr   = busAddr_q;

endmodule

// File: tb/tb_intf_rd_arbiter.sv
// Bench for intf_rd_arbiter: directed requests, a bus slave model, and
// monitors that pop expected grants/responses from queues and compare.
module tb_intf_rd_arbiter;

    localparam int NR   = 4;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LAT  = 2;
    localparam int LAT1 = 1;

    typedef struct {
        int             idx;
        logic [7:0]     val;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR-1:0]    dropMask;
    logic [NR*AW-1:0] reqAddr;
    logic [NR-1:0]    gnt, rspValid;
    logic [DW-1:0]    rspData;
    logic             busy, busRead, busEnable;
    logic [AW-1:0]    busAddr;
    logic [DW-1:0]    busData;

    logic [NR-1:0]    req1;
    logic [NR*AW-1:0] reqAddr1;
    logic [NR-1:0]    gnt1, rspValid1;
    logic [DW-1:0]    rspData1;
    logic             busy1, busRead1, busEnable1;
    logic [AW-1:0]    busAddr1;
    logic [DW-1:0]    busData1;

    int checks = 0;
    int errors = 0;

    exp_t       expGnt[$];
    exp_t       expRsp[$];
    logic [7:0] expRsp1[$];
    int         enCycles[$];
    int         en1Cycles[$];
    int         cyc = 0;
    int         gntCyc = 0;
    int         cyc1 = 0;
    int         gntCyc1 = 0;

    int         slaveCnt = 0;
    logic [7:0] slaveAddr = 8'h00;
    int         slaveCnt1 = 0;
    logic [7:0] slaveAddr1 = 8'h00;

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    intf_rd_arbiter #(.NUM_REQ(NR), .RD_LAT(LAT), .AW(AW), .DW(DW)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(reqAddr),
        .gnt(gnt), .rsp_valid(rspValid), .rsp_data(rspData), .busy(busy),
        .bus_read(busRead), .bus_enable(busEnable), .bus_addr(busAddr),
        .bus_data(busData)
    );

    intf_rd_arbiter #(.NUM_REQ(NR), .RD_LAT(LAT1), .AW(AW), .DW(DW)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .req_addr(reqAddr1),
        .gnt(gnt1), .rsp_valid(rspValid1), .rsp_data(rspData1), .busy(busy1),
        .bus_read(busRead1), .bus_enable(busEnable1), .bus_addr(busAddr1),
        .bus_data(busData1)
    );

    // Bus slaves: data = addr ^ 0x99, driven only in the last cycle of the latency window.
    always @(posedge clk) begin
        if (busEnable) begin
            slaveCnt  <= LAT;
            slaveAddr <= busAddr;
        end else if (slaveCnt != 0) begin
            slaveCnt <= slaveCnt - 1;
        end
        if (busEnable1) begin
            slaveCnt1  <= LAT1;
            slaveAddr1 <= busAddr1;
        end else if (slaveCnt1 != 0) begin
            slaveCnt1 <= slaveCnt1 - 1;
        end
    end

    assign busData  = (slaveCnt == 1)  ? (slaveAddr ^ 8'h99)  : 8'hEE;
    assign busData1 = (slaveCnt1 == 1) ? (slaveAddr1 ^ 8'h99) : 8'hEE;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // Main-DUT monitor: every grant and every response pops its expected entry.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (gnt != '0 || busEnable) begin
                enCycles.push_back(cyc);
                gntCyc = cyc;
                if (expGnt.size() == 0) begin
                    checkOutput("unexpected gnt", 32'(gnt), 32'(0));
                end else begin
                    e = expGnt.pop_front();
                    checkOutput("gnt onehot", 32'(gnt), 32'(1) << e.idx);
                    checkOutput("bus enable/read", {30'b0, busEnable, busRead}, 32'd3);
                    checkOutput("bus_addr", 32'(busAddr), 32'(e.val));
                    checkOutput("busy in issue", 32'(busy), 32'd1);
                end
            end
            if (rspValid != '0) begin
                if (expRsp.size() == 0) begin
                    checkOutput("unexpected rsp_valid", 32'(rspValid), 32'(0));
                end else begin
                    e = expRsp.pop_front();
                    checkOutput("rsp_valid onehot", 32'(rspValid), 32'(1) << e.idx);
                    checkOutput("rsp_data", 32'(rspData), 32'(e.val));
                    checkOutput("rsp latency", 32'(cyc - gntCyc), 32'(LAT + 1));
                    checkOutput("gnt overlaps rsp", 32'(gnt), 32'(0));
                    checkOutput("busy at rsp", 32'(busy), 32'd0);
                end
            end
        end
    end

    // RD_LAT=1 monitor: requester 0 only, response data popped from its own queue.
    always @(negedge clk) begin
        logic [7:0] d;
        cyc1++;
        if (rst_n) begin
            if (gnt1 != '0) begin
                en1Cycles.push_back(cyc1);
                gntCyc1 = cyc1;
                checkOutput("u1 gnt", 32'(gnt1), 32'd1);
                checkOutput("u1 bus_enable", 32'(busEnable1), 32'd1);
            end
            if (rspValid1 != '0) begin
                if (expRsp1.size() == 0) begin
                    checkOutput("u1 unexpected rsp_valid", 32'(rspValid1), 32'(0));
                end else begin
                    d = expRsp1.pop_front();
                    checkOutput("u1 rsp_valid", 32'(rspValid1), 32'd1);
                    checkOutput("u1 rsp_data", 32'(rspData1), 32'(d));
                    checkOutput("u1 rsp latency", 32'(cyc1 - gntCyc1), 32'(LAT1 + 1));
                end
            end
        end
    end

    // One cycle step; requesters in dropMask release req once they see their gnt.
    task automatic tick();
        @(negedge clk);
        req = req & ~(gnt & dropMask);
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR-1:0] drop);
        req      = r;
        dropMask = drop;
    endtask

    task automatic pushTxn(input int idx, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        e.idx = idx; e.val = addr;
        expGnt.push_back(e);
        e.val = data;
        expRsp.push_back(e);
    endtask

    task automatic pushGntOnly(input int idx, input logic [7:0] addr);
        exp_t e;
        e.idx = idx; e.val = addr;
        expGnt.push_back(e);
    endtask

    task automatic waitIdle(input string name, input int maxCycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            tick();
            if (expGnt.size() == 0 && expRsp.size() == 0 && expRsp1.size() == 0 &&
                !busy && !busy1 && req == '0 && req1 == '0)
                done = 1'b1;
        end
        if (!done) failTimeout(name);
        repeat (3) tick();
    endtask

    task automatic waitGnt(input string name, input int maxCycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            tick();
            if (gnt != '0) seen = 1'b1;
        end
        if (!seen) failTimeout(name);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rst_n    = 1'b1;
        req      = '0;
        dropMask = '0;
        req1     = '0;
        reqAddr  = {8'h43, 8'h5A, 8'h21, 8'h10};
        reqAddr1 = {8'h00, 8'h00, 8'h00, 8'h33};
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset gnt", 32'(gnt), 32'd0);
        checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("reset rsp_data", 32'(rspData), 32'd0);
        checkOutput("reset bus", {23'b0, busRead, busEnable, busAddr}, 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        $display("[TB] single request from requester 2");
        tick();
        pushTxn(2, 8'h5A, 8'hC3);
        applyStimulus(4'b0100, 4'b0100);
        waitIdle("single request", 30);

        $display("[TB] all four requesting from reset release");
        rst_n = 1'b0;
        pushTxn(0, 8'h10, 8'h89);
        pushTxn(1, 8'h21, 8'hB8);
        pushTxn(2, 8'h5A, 8'hC3);
        pushTxn(3, 8'h43, 8'hDA);
        applyStimulus(4'b1111, 4'b1111);
        tick();
        tick();
        base = enCycles.size();
        rst_n = 1'b1;
        waitIdle("four requesters", 60);
        if (enCycles.size() >= base + 4) begin
            for (int k = 1; k < 4; k++)
                checkOutput("enable spacing", 32'(enCycles[base+k] - enCycles[base+k-1]), 32'd4);
        end else begin
            failTimeout("four enable pulses");
        end
        pushTxn(0, 8'h10, 8'h89);
        pushTxn(3, 8'h43, 8'hDA);
        applyStimulus(4'b1001, 4'b1001);
        waitIdle("re-raised 0 and 3", 40);

        $display("[TB] requester 1 holds req while 3 competes");
        pushTxn(1, 8'h21, 8'hB8);
        pushTxn(3, 8'h43, 8'hDA);
        pushTxn(1, 8'h21, 8'hB8);
        pushTxn(3, 8'h43, 8'hDA);
        base = enCycles.size();
        applyStimulus(4'b1010, 4'b0000);
        for (int i = 0; i < 40 && enCycles.size() < base + 4; i++) tick();
        if (enCycles.size() < base + 4) failTimeout("alternating grants");
        req = '0;
        waitIdle("alternating grants", 40);

        $display("[TB] reset in second wait cycle");
        pushGntOnly(2, 8'h5A);
        applyStimulus(4'b0100, 4'b0100);
        waitGnt("grant before abort", 10);
        tick();
        tick();
        checkOutput("busy before abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort gnt/rsp_valid", {24'b0, gnt, rspValid}, 32'd0);
        checkOutput("abort rsp_data", 32'(rspData), 32'd0);
        checkOutput("abort bus", {23'b0, busRead, busEnable, busAddr}, 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        pushTxn(0, 8'h10, 8'h89);
        pushTxn(2, 8'h5A, 8'hC3);
        pushTxn(3, 8'h43, 8'hDA);
        applyStimulus(4'b1101, 4'b1101);
        waitIdle("after abort", 60);

        $display("[TB] short request from 2 during another transaction");
        pushTxn(0, 8'h10, 8'h89);
        base = enCycles.size();
        applyStimulus(4'b0001, 4'b0001);
        waitGnt("grant for requester 0", 10);
        tick();
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        waitIdle("short request", 30);
        repeat (6) tick();
        checkOutput("enable count", 32'(enCycles.size() - base), 32'd1);

        $display("[TB] RD_LAT=1 instance, back-to-back from requester 0");
        expRsp1.push_back(8'hAA);
        expRsp1.push_back(8'hAA);
        base = en1Cycles.size();
        req1 = 4'b0001;
        for (int i = 0; i < 20 && en1Cycles.size() < base + 2; i++) tick();
        req1 = '0;
        if (en1Cycles.size() >= base + 2)
            checkOutput("u1 enable spacing", 32'(en1Cycles[base+1] - en1Cycles[base]), 32'd3);
        else
            failTimeout("u1 two grants");
        waitIdle("u1 responses", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
